gpio_ctrl: RTL and testbench

Parametrised memory-mapped GPIO peripheral for the Yduck SoC data bus, replacing direct gpio_in/gpio_out wiring. Adds per-bit direction control, an input synchroniser, atomic set/clear of outputs, and per-bit rising/falling edge interrupts with a write-1-to-clear status register. Sits on the core's load/store bus beside RAM; drives the SoC pads and one interrupt line.

---
 rtl/gpio_ctrl.sv | 102 ++++++++++
 tb/tb_gpio_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, set/clear, synchronised inputs and edge interrupts
module gpio_ctrl #(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_i,
    input  logic          re_i,
    output logic [DW-1:0] rdata_o,
    input  logic [DW-1:0] gpio_in_i,
    output logic [DW-1:0] gpio_out_o,
    output logic [DW-1:0] gpio_oe_o,
    output logic          irq_o
);
    localparam logic [2:0] A_DIN  = 3'd0;
    localparam logic [2:0] A_DOUT = 3'd1;
    localparam logic [2:0] A_DIR  = 3'd2;
    localparam logic [2:0] A_RISE = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [DW-1:0] sync_q [SYNC_STAGES];
    logic [DW-1:0] prev_q;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] dir_q, dir_d;
    logic [DW-1:0] rise_en_q, rise_en_d;
    logic [DW-1:0] fall_en_q, fall_en_d;
    logic [DW-1:0] stat_q, stat_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] s, evt, rd_val;
    logic [2:0]    idx;
    logic          in_map, wr;

    assign s      = sync_q[SYNC_STAGES-1];
    assign idx    = addr_i[2:0];
    assign in_map = (addr_i >> 3) == '0;
    assign wr     = we_i && in_map;
    // edges only count on input pins, judged on the synchronised sample against the previous one
    assign evt    = ((s & ~prev_q & rise_en_q) | (~s & prev_q & fall_en_q)) & ~dir_q;

    // register read mux and next-state for all software-visible registers
    always_comb begin
        rd_val    = !in_map ? '0 :
                    idx == A_DIN  ? s :
                    idx == A_DOUT ? dout_q :
                    idx == A_DIR  ? dir_q :
                    idx == A_RISE ? rise_en_q :
                    idx == A_FALL ? fall_en_q :
                    idx == A_STAT ? stat_q : '0;
        rdata_d   = re_i ? rd_val : rdata_q;
        dout_d    = !wr ? dout_q :
                    idx == A_DOUT ? wdata_i :
                    idx == A_SET  ? (dout_q | wdata_i) :
                    idx == A_CLR  ? (dout_q & ~wdata_i) : dout_q;
        dir_d     = (wr && idx == A_DIR)  ? wdata_i : dir_q;
        rise_en_d = (wr && idx == A_RISE) ? wdata_i : rise_en_q;
        fall_en_d = (wr && idx == A_FALL) ? wdata_i : fall_en_q;
        stat_d    = (stat_q & ~((wr && idx == A_STAT) ? wdata_i : '0)) | evt;
    end

    // input synchroniser chain and previous-sample register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= s;
        end
    end

    // control/status registers and registered read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q    <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            rdata_q   <= '0;
        end else begin
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign gpio_out_o = dout_q;
    assign gpio_oe_o  = dir_q;
    assign irq_o      = |stat_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed test of gpio_ctrl against a register-level behavioural model
module tb_gpio_ctrl;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [DW-1:0] rdata;
    logic [DW-1:0] gpio_in = '0;
    logic [DW-1:0] gpio_out;
    logic [DW-1:0] gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_ctrl #(.DW(DW), .SYNC_STAGES(SS), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata), .we_i(we), .re_i(re),
        .rdata_o(rdata), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // model: register contents plus the history of pad values seen at each clock edge;
    // the synchronised view is the value captured SS edges ago, "prev" the one before it
    logic [DW-1:0] m_hist [0:SS];
    logic [DW-1:0] m_dout, m_dir, m_rise, m_fall, m_stat, m_rdata;
    wire  [DW-1:0] m_s    = m_hist[SS-1];
    wire  [DW-1:0] m_prev = m_hist[SS];
    wire  [DW-1:0] m_evt  = ((m_s & ~m_prev & m_rise) | (~m_s & m_prev & m_fall)) & ~m_dir;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        case (a)
            0: return m_s;
            1: return m_dout;
            2: return m_dir;
            3: return m_rise;
            4: return m_fall;
            5: return m_stat;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SS; i++) m_hist[i] <= '0;
            m_dout <= '0; m_dir <= '0; m_rise <= '0; m_fall <= '0; m_stat <= '0; m_rdata <= '0;
        end else begin
            m_hist[0] <= gpio_in;
            for (int i = 1; i <= SS; i++) m_hist[i] <= m_hist[i-1];
            if (re) m_rdata <= m_read(addr);
            if (we && addr == 1) m_dout <= wdata;
            if (we && addr == 6) m_dout <= m_dout | wdata;
            if (we && addr == 7) m_dout <= m_dout & ~wdata;
            if (we && addr == 2) m_dir <= wdata;
            if (we && addr == 3) m_rise <= wdata;
            if (we && addr == 4) m_fall <= wdata;
            m_stat <= (m_stat & ~((we && addr == 5) ? wdata : '0)) | m_evt;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // every cycle out of reset: all outputs must match the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gpio_out", gpio_out, m_dout);
            chk("gpio_oe", gpio_oe, m_dir);
            chk("irq", {15'd0, irq}, {15'd0, |m_stat});
            chk("rdata", rdata, m_rdata);
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        v = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [DW-1:0] v;

    initial begin
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        chk("rst gpio_out", gpio_out, 16'h0000);
        chk("rst gpio_oe", gpio_oe, 16'h0000);
        chk("rst irq", {15'd0, irq}, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            rd(AW'(a), v);
            chk("rst read", v, 16'h0000);
        end
        wr(1, 16'h00F0);
        wr(6, 16'h0F01);
        wr(7, 16'h0030);
        chk("set/clr gpio_out", gpio_out, 16'h0FC1);
        rd(6, v); chk("read SET", v, 16'h0000);
        rd(7, v); chk("read CLR", v, 16'h0000);
        rd(1, v); chk("read DOUT", v, 16'h0FC1);
        gpio_in = 16'hFA1C;
        idle(1);
        rd(0, v); chk("DIN early", v, 16'h0000);
        rd(0, v); chk("DIN synced", v, 16'hFA1C);
        gpio_in = 16'h0000;
        idle(4);
        wr(3, 16'h0001);
        gpio_in = 16'h0001;
        idle(1); chk("rise lat e0", {15'd0, irq}, 16'h0000);
        idle(1); chk("rise lat e1", {15'd0, irq}, 16'h0000);
        idle(1); chk("rise lat e2", {15'd0, irq}, 16'h0001);
        rd(5, v); chk("STAT rise", v, 16'h0001);
        wr(5, 16'h0001);
        chk("w1c irq", {15'd0, irq}, 16'h0000);
        wr(4, 16'h8000);
        gpio_in = 16'h8001; idle(4);
        gpio_in = 16'h0001; idle(4);
        rd(5, v); chk("STAT fall", v, 16'h8000);
        gpio_in = 16'h8001; idle(4);
        gpio_in = 16'h0001; idle(2);
        wr(5, 16'h8000);
        chk("collision irq", {15'd0, irq}, 16'h0001);
        rd(5, v); chk("collision STAT", v, 16'h8000);
        wr(5, 16'h8000);
        chk("clear irq", {15'd0, irq}, 16'h0000);
        wr(2, 16'h8000);
        chk("gpio_oe dir", gpio_oe, 16'h8000);
        gpio_in = 16'h8001; idle(4);
        gpio_in = 16'h0001; idle(4);
        rd(5, v); chk("STAT output pin", v, 16'h0000);
        wr(2, 16'h0000);
        idle(4);
        rd(5, v); chk("STAT dir 1->0", v, 16'h0000);
        wr(3, 16'h0003);
        gpio_in = 16'h0000; idle(4);
        gpio_in = 16'h0003; idle(4);
        wr(1, 16'hFFFF);
        rd(5, v); chk("STAT pre-reset", v, 16'h0003);
        chk("gpio_out pre-reset", gpio_out, 16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async gpio_out", gpio_out, 16'h0000);
        chk("async irq", {15'd0, irq}, 16'h0000);
        chk("async gpio_oe", gpio_oe, 16'h0000);
        gpio_in = 16'h0000;
        idle(2);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(AW'(a), v);
            chk("post-reset read", v, 16'h0000);
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
